// File: rtl/instr_queue.sv
// instr_queue: circular fetch-to-decode FIFO that tags entries written after an unresolved branch
// as speculative and squashes or promotes them when the branch resolves.
module instr_queue #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wr_en_i,
    input  logic [31:0]      wr_instr_i,
    input  logic             wr_is_branch_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [31:0]      rd_instr_o,
    output logic             rd_spec_o,
    input  logic             cond_eval_i,
    input  logic             corr_pred_i,
    output logic [PTR_W:0]   count_o
);
    localparam int CW = PTR_W + 1;

    logic [31:0]      mem [DEPTH];
    logic [DEPTH-1:0] spec_q, spec_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d, spec_cnt, spec_cnt_d, squash_n;
    logic             spec_active, spec_active_d;
    logic             resolve, squash, pop, pop_spec, push, wr_spec;

    assign rd_valid_o = count_q != '0;
    assign full_o     = count_q == CW'(DEPTH);
    assign count_o    = count_q;
    assign rd_instr_o = rd_valid_o ? mem[rd_ptr] : '0;
    assign rd_spec_o  = rd_valid_o & spec_q[rd_ptr];

    assign resolve  = cond_eval_i & spec_active;
    assign squash   = resolve & ~corr_pred_i;
    assign pop      = rd_en_i & rd_valid_o;
    assign pop_spec = pop & spec_q[rd_ptr];
    assign push     = wr_en_i & ~full_o & ~squash;
    // Resolution happens before the write, so a same-cycle write sees the resolved state.
    assign wr_spec  = spec_active & ~resolve & ~wr_is_branch_i;
    // Speculative entries still held after a same-cycle pop of a speculative head.
    assign squash_n = squash ? spec_cnt - CW'(pop_spec) : '0;

    always_comb begin
        spec_d = resolve ? '0 : spec_q;
        if (push) spec_d[wr_ptr] = wr_spec;
        wr_ptr_d      = squash ? wr_ptr - squash_n[PTR_W-1:0] : wr_ptr + PTR_W'(push);
        count_d       = count_q - CW'(pop) - squash_n + CW'(push);
        spec_cnt_d    = (resolve ? '0 : spec_cnt - CW'(pop_spec)) + CW'(push & wr_spec);
        spec_active_d = (spec_active & ~resolve) | (push & wr_is_branch_i);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            spec_cnt    <= '0;
            spec_active <= 1'b0;
            spec_q      <= '0;
        end else begin
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr + PTR_W'(pop);
            count_q     <= count_d;
            spec_cnt    <= spec_cnt_d;
            spec_active <= spec_active_d;
            spec_q      <= spec_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_instr_i;
    end
endmodule
